// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial-in / parallel-out shift register.
package shift_reg_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int SHIFT_REG_DEFAULT_WIDTH = 4;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_if.sv
// Bundle of the shift-register control/data signals for benches and parent blocks.
interface shift_reg_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
) (
  input logic clk
);

  logic             data;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] out;

  modport master (
    input  clk,
    output data,
    output en,
    output dir,
    input  out
  );

  modport slave (
    input  clk,
    input  data,
    input  en,
    input  dir,
    output out
  );

endinterface : shift_reg_if

// File: rtl/shift_reg.sv
// Bidirectional serial-in shift register; out is taken straight from the flops.
// Port list stays flat and in fixed order so positional instantiation keeps working.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             data,
  input  logic             en,
  input  logic             dir,
  input  logic             rstn,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] next_s;

  // Next-state select: hold, shift toward MSB, or shift toward LSB.
  // dir is only examined while en is high, so X on dir/data during hold is ignored.
  always_comb begin
    next_s = shift_r;
    if (en) begin
      case (dir)
        DIR_LEFT:  next_s = {shift_r[WIDTH-2:0], data};
        DIR_RIGHT: next_s = {data, shift_r[WIDTH-1:1]};
        default:   next_s = shift_r;
      endcase
    end else begin
      next_s = shift_r;
    end
  end

  // Register with synchronous reset; rstn is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rstn) begin
      shift_r <= {WIDTH{1'b0}};
    end else begin
      shift_r <= next_s;
    end
  end

  assign out = shift_r;

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// Directed bench for shift_reg: reset, left/right shifts, hold, reversal, mid-run reset.
module tb_shift_reg;
  import shift_reg_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rstn;
  int   checks_r;
  int   errors_r;

  shift_reg_if #(.WIDTH(W)) bus (.clk(clk));

  shift_reg #(.WIDTH(W)) dut (
    .clk  (clk),
    .data (bus.data),
    .en   (bus.en),
    .dir  (bus.dir),
    .rstn (rstn),
    .out  (bus.out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic d, input logic e, input logic dr, input logic r);
    @(negedge clk);
    bus.data = d;
    bus.en   = e;
    bus.dir  = dr;
    rstn     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    bus.data = 1'b0;
    bus.en   = 1'b0;
    bus.dir  = DIR_LEFT;
    rstn     = 1'b0;

    // Reset overrides an active shift with data=1
    step(1'b1, 1'b1, DIR_LEFT, 1'b1);
    check_val("rst_edge1", bus.out, 4'b0000);
    step(1'b1, 1'b1, DIR_LEFT, 1'b1);
    check_val("rst_edge2", bus.out, 4'b0000);

    // Left shift 1,0,1,1
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("left_1", bus.out, 4'b0001);
    step(1'b0, 1'b1, DIR_LEFT, 1'b0);
    check_val("left_2", bus.out, 4'b0010);
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("left_3", bus.out, 4'b0101);
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("left_4", bus.out, 4'b1011);

    // Hold with data/dir toggling, then with X on data/dir
    for (int i = 0; i < 5; i++) begin
      step(i[0], 1'b0, ~i[0], 1'b0);
      check_val($sformatf("hold_%0d", i), bus.out, 4'b1011);
    end
    step(1'bx, 1'b0, 1'bx, 1'b0);
    check_val("hold_x", bus.out, 4'b1011);

    // Right shift 1,0,1,1 from reset
    step(1'b0, 1'b0, DIR_LEFT, 1'b1);
    check_val("rst_before_right", bus.out, 4'b0000);
    step(1'b1, 1'b1, DIR_RIGHT, 1'b0);
    check_val("right_1", bus.out, 4'b1000);
    step(1'b0, 1'b1, DIR_RIGHT, 1'b0);
    check_val("right_2", bus.out, 4'b0100);
    step(1'b1, 1'b1, DIR_RIGHT, 1'b0);
    check_val("right_3", bus.out, 4'b1010);
    step(1'b1, 1'b1, DIR_RIGHT, 1'b0);
    check_val("right_4", bus.out, 4'b1101);

    // Direction reversal with no bubble
    step(1'b0, 1'b0, DIR_LEFT, 1'b1);
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("rev_seed", bus.out, 4'b0001);
    step(1'b0, 1'b1, DIR_LEFT, 1'b0);
    check_val("rev_left", bus.out, 4'b0010);
    step(1'b1, 1'b1, DIR_RIGHT, 1'b0);
    check_val("rev_right", bus.out, 4'b1001);

    // Mid-operation reset discards contents
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("mid_shift", bus.out, 4'b0011);
    step(1'b1, 1'b1, DIR_RIGHT, 1'b1);
    check_val("mid_rst", bus.out, 4'b0000);
    step(1'b1, 1'b1, DIR_LEFT, 1'b0);
    check_val("post_rst_left", bus.out, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule : tb_shift_reg
